mem_lsu_stage: RTL and testbench

// - Parametrised MEM stage for the 5-stage RV pipeline. Sits between EX/MEM and MEM/WB.
// - Drives a req/ack data-memory port with variable wait states.
// - Generates byte enables and lane-shifts store data; extracts and sign/zero-extends load data.
// - Stalls upstream while an access is outstanding. Flags misaligned accesses and bus timeouts.

---
 rtl/mem_lsu_stage_pkg.sv | 47 ++++
 rtl/mem_lsu_stage_if.sv | 29 ++
 rtl/mem_lsu_stage_align.sv | 71 +++++++
 rtl/mem_lsu_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_lsu_stage.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_stage_pkg
// Brief    : Shared types, funct3 size codes and lane helpers for the MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_lsu_stage_pkg;

    typedef enum logic [0:0] {
        LSU_IDLE   = 1'b0,
        LSU_ACCESS = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam int WAIT_CNT_W = 8;

    // Number of address bits selecting a byte lane within one data word.
    function automatic int lane_bits(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

    // The low two funct3 bits encode log2 of the access size for every code.
    function automatic logic [1:0] f3_size_log2(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    function automatic logic f3_is_unsigned(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_supported(input logic [2:0] f3, input int xlen);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
            F3_D, F3_WU:                    return (xlen == 64);
            default:                        return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_stage_if
// Brief    : Data-memory req/ack port between the MEM stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_lsu_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) ();
    logic                req;
    logic                we;
    logic [XLEN/8-1:0]   be;
    logic [ADDR_W-1:0]   addr;
    logic [XLEN-1:0]     wdata;
    logic                ack;
    logic [XLEN-1:0]     rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ack, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu_stage_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_align
// Brief    : Combinational byte-enable/store-lane shift and load extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu_align
    import mem_lsu_stage_pkg::*;
#(
    parameter  int XLEN      = 32,
    localparam int LANE_BITS = lane_bits(XLEN),
    localparam int BE_W      = XLEN / 8
) (
    input  logic [2:0]           funct3,
    input  logic [LANE_BITS-1:0] offset,
    input  logic [XLEN-1:0]      store_data,
    input  logic [XLEN-1:0]      rdata,
    output logic [BE_W-1:0]      be,
    output logic [XLEN-1:0]      lane_wdata,
    output logic [XLEN-1:0]      load_data,
    output logic                 misaligned
);

    logic [1:0]           size_log2;
    logic [BE_W-1:0]      size_mask;
    logic [LANE_BITS-1:0] align_mask;
    logic [XLEN-1:0]      keep_mask;
    logic [XLEN-1:0]      lane;
    logic                 sign_bit;
    logic                 fill;

    always_comb begin
        size_log2 = f3_size_log2(funct3);
        lane      = rdata >> {offset, 3'b000};
        case (size_log2)
            2'd0: begin
                size_mask  = BE_W'(8'h01);
                align_mask = LANE_BITS'(3'd0);
                keep_mask  = XLEN'(64'h0000_0000_0000_00FF);
                sign_bit   = lane[7];
            end
            2'd1: begin
                size_mask  = BE_W'(8'h03);
                align_mask = LANE_BITS'(3'd1);
                keep_mask  = XLEN'(64'h0000_0000_0000_FFFF);
                sign_bit   = lane[15];
            end
            2'd2: begin
                size_mask  = BE_W'(8'h0F);
                align_mask = LANE_BITS'(3'd3);
                keep_mask  = XLEN'(64'h0000_0000_FFFF_FFFF);
                sign_bit   = lane[31];
            end
            default: begin
                size_mask  = BE_W'(8'hFF);
                align_mask = LANE_BITS'(3'd7);
                keep_mask  = '1;
                sign_bit   = lane[XLEN-1];
            end
        endcase

        fill       = sign_bit & ~f3_is_unsigned(funct3);
        load_data  = (lane & keep_mask) | ({XLEN{fill}} & ~keep_mask);
        be         = size_mask << offset;
        lane_wdata = store_data << {offset, 3'b000};
        // Unsupported size codes are reported through the misalign path.
        misaligned = !f3_supported(funct3, XLEN) || ((offset & align_mask) != '0);
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_stage
// Brief    : MEM pipeline stage: req/ack data-memory access with wait states,
//            misalign and timeout detection, registered write-back outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu_stage
    import mem_lsu_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              arst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              rd_we,
    input  logic [4:0]        rd_addr,

    mem_lsu_stage_if.master   dmem,

    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_misalign,
    output logic              exc_timeout
);

    localparam int                    LANE_BITS = lane_bits(XLEN);
    localparam int                    BE_W      = XLEN / 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    lsu_state_e             state;
    logic [WAIT_CNT_W-1:0]  wait_cnt;

    logic                   dmem_req;
    logic                   dmem_we;
    logic [BE_W-1:0]        dmem_be;
    logic [ADDR_W-1:0]      dmem_addr;
    logic [XLEN-1:0]        dmem_wdata;

    logic [2:0]             funct3_q;
    logic [LANE_BITS-1:0]   offset_q;
    logic                   rd_we_q;

    logic [2:0]             sel_funct3;
    logic [LANE_BITS-1:0]   sel_offset;
    logic [BE_W-1:0]        be;
    logic [XLEN-1:0]        lane_wdata;
    logic [XLEN-1:0]        load_data;
    logic                   misaligned;
    logic                   is_mem;
    logic [XLEN-1:0]        addr_data;
    logic [ADDR_W-1:0]      word_addr;

    assign is_mem    = is_load | is_store;
    assign addr_data = XLEN'(addr);
    assign word_addr = {addr[ADDR_W-1:LANE_BITS], LANE_BITS'(0)};

    // One align unit serves both phases: incoming op in IDLE, latched op in ACCESS.
    assign sel_funct3 = (state == LSU_ACCESS) ? funct3_q : funct3;
    assign sel_offset = (state == LSU_ACCESS) ? offset_q : addr[LANE_BITS-1:0];

    mem_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3     (sel_funct3),
        .offset     (sel_offset),
        .store_data (wdata),
        .rdata      (dmem.rdata),
        .be         (be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign dmem.req   = dmem_req;
    assign dmem.we    = dmem_we;
    assign dmem.be    = dmem_be;
    assign dmem.addr  = dmem_addr;
    assign dmem.wdata = dmem_wdata;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state        <= LSU_IDLE;
            wait_cnt     <= '0;
            in_ready     <= 1'b1;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_be      <= '0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            funct3_q     <= '0;
            offset_q     <= '0;
            rd_we_q      <= 1'b0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            exc_misalign <= 1'b0;
            exc_timeout  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            exc_misalign <= 1'b0;
            exc_timeout  <= 1'b0;

            case (state)
                LSU_IDLE: begin
                    if (in_valid) begin
                        wb_addr <= rd_addr;
                        wb_data <= addr_data;
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_we    <= rd_we && (rd_addr != 5'd0);
                        end else if (misaligned) begin
                            wb_valid     <= 1'b1;
                            exc_misalign <= 1'b1;
                        end else begin
                            state      <= LSU_ACCESS;
                            in_ready   <= 1'b0;
                            wait_cnt   <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_be    <= be;
                            dmem_addr  <= word_addr;
                            dmem_wdata <= lane_wdata;
                            funct3_q   <= funct3;
                            offset_q   <= addr[LANE_BITS-1:0];
                            rd_we_q    <= rd_we;
                        end
                    end
                end

                LSU_ACCESS: begin
                    // Ack takes priority over the final wait cycle.
                    if (dmem.ack) begin
                        state    <= LSU_IDLE;
                        in_ready <= 1'b1;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        if (!dmem_we) begin
                            wb_we   <= rd_we_q && (wb_addr != 5'd0);
                            wb_data <= load_data;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= LSU_IDLE;
                        in_ready    <= 1'b1;
                        dmem_req    <= 1'b0;
                        wb_valid    <= 1'b1;
                        exc_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end

                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu_stage
// Brief    : Scoreboard bench for mem_lsu_stage with a responding memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu_stage;

    localparam int XLEN     = 32;
    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 15;
    localparam int N_RANDOM = 250;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              is_load = 1'b0;
    logic              is_store = 1'b0;
    logic [2:0]        funct3 = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic [XLEN-1:0]   wdata = '0;
    logic              rd_we = 1'b0;
    logic [4:0]        rd_addr = '0;
    logic              wb_valid;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              exc_misalign;
    logic              exc_timeout;

    mem_lsu_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dmem_bus ();

    mem_lsu_stage #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .is_load      (is_load),
        .is_store     (is_store),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rd_we        (rd_we),
        .rd_addr      (rd_addr),
        .dmem         (dmem_bus),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .exc_misalign (exc_misalign),
        .exc_timeout  (exc_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    bit resp_en  = 1'b0;

    typedef struct {
        bit        we;
        bit [4:0]  waddr;
        bit [31:0] data;
        bit        chk_data;
        bit        mis;
        bit        tmo;
        int        exp_cycle;
    } wb_exp_t;

    typedef struct {
        bit        we;
        bit [3:0]  be;
        bit [31:0] addr;
        bit [31:0] wd;
        int        off;
        int        nbytes;
        bit [31:0] rdata;
        int        waits;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Memory responder: checks each request against the expected access, then acks.
    initial begin
        req_exp_t r;
        int       nh;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en && dmem_bus.req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 64'(dmem_bus.req), 64'd0);
                end else begin
                    r  = req_q.pop_front();
                    nh = (r.waits < MAX_WAIT) ? r.waits + 1 : MAX_WAIT;
                    chk("req_we", 64'(dmem_bus.we), 64'(r.we));
                    chk("req_be", 64'(dmem_bus.be), 64'(r.be));
                    chk("req_addr", 64'(dmem_bus.addr), 64'(r.addr));
                    if (r.we) begin
                        for (int k = 0; k < r.nbytes; k++)
                            chk("req_wdata_lane", 64'(dmem_bus.wdata[8*(r.off+k) +: 8]),
                                64'(r.wd[8*k +: 8]));
                    end
                    for (int c = 1; c <= nh; c++) begin
                        chk("req_held", 64'({dmem_bus.req, dmem_bus.we, dmem_bus.be, dmem_bus.addr}),
                            64'({1'b1, r.we, r.be, r.addr}));
                        if (c == r.waits + 1) begin
                            dmem_bus.ack   = 1'b1;
                            dmem_bus.rdata = r.rdata;
                        end
                        @(negedge clk);
                        dmem_bus.ack   = 1'b0;
                        dmem_bus.rdata = $urandom;
                    end
                    chk("req_released", 64'(dmem_bus.req), 64'd0);
                end
            end
        end
    end

    // Write-back monitor: pops the scoreboard whenever the stage retires.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wb_valid) begin
                    if (wb_q.size() == 0) begin
                        chk("unexpected_wb", 64'(wb_valid), 64'd0);
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_cycle", 64'(cyc), 64'(e.exp_cycle));
                        chk("wb_we", 64'(wb_we), 64'(e.we));
                        chk("wb_addr", 64'(wb_addr), 64'(e.waddr));
                        chk("exc_misalign", 64'(exc_misalign), 64'(e.mis));
                        chk("exc_timeout", 64'(exc_timeout), 64'(e.tmo));
                        if (e.chk_data) chk("wb_data", 64'(wb_data), 64'(e.data));
                    end
                end else begin
                    chk("exc_without_wb", 64'({exc_misalign, exc_timeout}), 64'd0);
                    if (wb_q.size() != 0 && wb_q[0].exp_cycle < cyc) begin
                        chk("wb_missing", 64'(wb_valid), 64'd1);
                        e = wb_q.pop_front();
                    end
                end
            end
        end
    end

    // Issue one entry at a negedge; builds expectations from the access rules.
    task automatic issue(input bit ld, input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit rwe, input bit [4:0] rd,
                         input bit [31:0] rdat, input int waits);
        bit        mem, mis;
        int        n, o, nh, lat;
        bit [63:0] mask, val;
        wb_exp_t   e;
        req_exp_t  r;
        e   = '{default: 0};
        r   = '{default: 0};
        mem = ld || st;
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        o   = int'(a % 4);
        mis = mem && ((n == 0) || ((a % n) != 0));
        nh  = (waits < MAX_WAIT) ? waits + 1 : MAX_WAIT;

        chk("in_ready_idle", 64'(in_ready), 64'd1);
        if (!mem) begin
            e.we = rwe && (rd != 0); e.data = a; e.chk_data = 1'b1; lat = 1;
        end else if (mis) begin
            e.mis = 1'b1; lat = 1;
        end else begin
            lat      = nh + 1;
            r.we     = st;
            r.be     = 4'(((1 << n) - 1) << o);
            r.addr   = a & ~32'h3;
            r.wd     = wd;
            r.off    = o;
            r.nbytes = n;
            r.rdata  = rdat;
            r.waits  = waits;
            if (waits >= MAX_WAIT) begin
                e.tmo = 1'b1;
            end else if (!st) begin
                mask = (64'd1 << (8 * n)) - 64'd1;
                val  = (64'(rdat) >> (8 * o)) & mask;
                if (f3 < 3'd4 && val[8*n-1]) val = val | ~mask;
                e.data = val[31:0]; e.chk_data = 1'b1; e.we = rwe && (rd != 0);
            end
            req_q.push_back(r);
        end
        e.waddr = rd;
        e.exp_cycle = cyc + lat;
        wb_q.push_back(e);

        in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        addr = a; wdata = wd; rd_we = rwe; rd_addr = rd;
        @(negedge clk);
        in_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        if (mem && !mis) begin
            repeat (nh) begin
                chk("in_ready_busy", 64'(in_ready), 64'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit        ld, st;
        bit [2:0]  f3;
        bit [31:0] a;
        int        kind, wsel, waits;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_dmem_req", 64'(dmem_bus.req), 64'd0);
        chk("rst_outputs", 64'({wb_valid, wb_we, exc_misalign, exc_timeout, dmem_bus.we, dmem_bus.be}), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Reset while an access is outstanding.
        in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h0000_5000; rd_we = 1'b1; rd_addr = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("access_req_up", 64'(dmem_bus.req), 64'd1);
        chk("access_in_ready", 64'(in_ready), 64'd0);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        chk("mid_rst_req", 64'(dmem_bus.req), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
        @(negedge clk);
        mon_en = 1'b1; resp_en = 1'b1;
        @(negedge clk);

        issue(1, 0, 3'b000, 32'h0000_1003, $urandom, 1, 5'd5, 32'h80FF_FF00, 0);
        issue(1, 0, 3'b101, 32'h0000_2002, $urandom, 1, 5'd7, 32'hBEEF_1234, 3);
        issue(0, 1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 1, 5'd9, $urandom, 0);
        issue(1, 0, 3'b010, 32'h0000_4001, $urandom, 1, 5'd4, $urandom, 0);
        issue(1, 0, 3'b010, 32'h0000_4004, $urandom, 1, 5'd0, 32'h1234_5678, 1);
        issue(1, 0, 3'b010, 32'h0000_4008, $urandom, 1, 5'd10, $urandom, MAX_WAIT);
        issue(1, 0, 3'b010, 32'h0000_400C, $urandom, 1, 5'd11, 32'hCAFE_F00D, MAX_WAIT - 1);
        issue(0, 0, 3'b000, 32'h1234_5678, $urandom, 1, 5'd12, $urandom, 0);
        issue(0, 0, 3'b000, 32'h8765_4321, $urandom, 1, 5'd0, $urandom, 0);
        issue(1, 1, 3'b000, 32'h0000_5001, 32'h0000_00AA, 1, 5'd13, $urandom, 0);
        issue(1, 0, 3'b011, 32'h0000_6000, $urandom, 1, 5'd14, $urandom, 0);
        issue(1, 0, 3'b110, 32'h0000_6000, $urandom, 1, 5'd15, $urandom, 0);
        issue(0, 1, 3'b111, 32'h0000_6000, $urandom, 1, 5'd16, $urandom, 0);
        issue(1, 0, 3'b001, 32'h0000_7001, $urandom, 1, 5'd17, $urandom, 0);
        issue(1, 0, 3'b100, 32'h0000_7002, $urandom, 1, 5'd18, 32'h00F7_0000, 2);

        for (int i = 0; i < N_RANDOM; i++) begin
            kind = $urandom_range(0, 3);
            ld   = (kind == 1) || (kind == 3);
            st   = (kind == 2) || (kind == 3);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a = a & ~32'h1;
                else if (f3[1:0] != 2'd0) a = a & ~32'h3;
            end
            wsel  = $urandom_range(0, 19);
            waits = (wsel < 15) ? (wsel % 5) : (12 + wsel - 15);
            issue(ld, st, f3, a, $urandom, 1'($urandom), 5'($urandom), $urandom, waits);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        repeat (MAX_WAIT + 5) @(negedge clk);
        chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        chk("req_queue_drained", 64'(req_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
